// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch/jal redirect flushes
// and data-memory wait handling with a sticky timeout error.
module pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_RD,
  input  logic [4:0]  IFID_RS1,
  input  logic [4:0]  IFID_RS2,
  input  logic        EXMEM_Branch,
  input  logic        EXMEM_Zero,
  input  logic        EXMEM_Jal,
  input  logic        EXMEM_MemRead,
  input  logic        EXMEM_MemWrite,
  input  logic        dmem_ready,
  output logic        PC_write,
  output logic        IFID_write,
  output logic        IDEX_write,
  output logic        EXMEM_write,
  output logic        IFID_flush,
  output logic        IDEX_flush,
  output logic        EXMEM_flush,
  output logic        PC_redirect,
  output logic        dmem_req,
  output logic        mem_err,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {S_IDLE, S_MEM_WAIT, S_ERROR} state_t;

  localparam logic [7:0] TIMEOUT = MEM_TIMEOUT[7:0];

  state_t      state_q;
  logic [7:0]  wait_cnt_q;
  logic        mem_err_q;
  logic [15:0] stall_cnt_q;

  logic mem_op, taken, hazard, freeze, bubble;

  always_comb begin
    mem_op = EXMEM_MemRead | EXMEM_MemWrite;
    taken  = (EXMEM_Branch & EXMEM_Zero) | EXMEM_Jal;
    hazard = IDEX_MemRead & (IDEX_RD != 5'd0) &
             ((IDEX_RD == IFID_RS1) | (IDEX_RD == IFID_RS2));

    dmem_req = 1'b0;
    freeze   = 1'b0;
    case (state_q)
      S_IDLE: begin
        dmem_req = mem_op;
        freeze   = mem_op & ~dmem_ready;
      end
      S_MEM_WAIT: begin
        dmem_req = 1'b1;
        freeze   = 1'b1;
      end
      S_ERROR: begin
        dmem_req = 1'b0;
        freeze   = 1'b1;
      end
      default: begin
        dmem_req = 1'b0;
        freeze   = 1'b1;
      end
    endcase

    bubble = hazard & ~taken & ~freeze;

    PC_write    = 1'b1;
    IFID_write  = 1'b1;
    IDEX_write  = 1'b1;
    EXMEM_write = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    EXMEM_flush = 1'b0;
    PC_redirect = 1'b0;

    // Priority freeze > taken > hazard; a held redirect fires once freeze drops.
    if (freeze) begin
      PC_write    = 1'b0;
      IFID_write  = 1'b0;
      IDEX_write  = 1'b0;
      EXMEM_write = 1'b0;
    end else if (taken) begin
      PC_redirect = 1'b1;
      IFID_flush  = 1'b1;
      IDEX_flush  = 1'b1;
      EXMEM_flush = 1'b1;
    end else if (hazard) begin
      PC_write   = 1'b0;
      IFID_write = 1'b0;
      IDEX_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      if ((freeze | bubble) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 16'd1;

      case (state_q)
        S_IDLE: begin
          if (mem_op && !dmem_ready) begin
            state_q    <= S_MEM_WAIT;
            wait_cnt_q <= '0;
          end
        end
        S_MEM_WAIT: begin
          if (dmem_ready) begin
            state_q <= S_IDLE;
          end else if (wait_cnt_q + 8'd1 == TIMEOUT) begin
            state_q   <= S_ERROR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
          end
        end
        S_ERROR: state_q <= S_ERROR;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_err     = mem_err_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (default timeout and a
// MEM_TIMEOUT=4 instance sharing the same inputs).
module tb_pipeline_ctrl;

  logic        clk;
  logic        reset;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_RD, IFID_RS1, IFID_RS2;
  logic        EXMEM_Branch, EXMEM_Zero, EXMEM_Jal;
  logic        EXMEM_MemRead, EXMEM_MemWrite;
  logic        dmem_ready;

  logic PC_write, IFID_write, IDEX_write, EXMEM_write;
  logic IFID_flush, IDEX_flush, EXMEM_flush, PC_redirect, dmem_req, mem_err;
  logic [15:0] stall_count;

  logic PC_write_t, IFID_write_t, IDEX_write_t, EXMEM_write_t;
  logic IFID_flush_t, IDEX_flush_t, EXMEM_flush_t, PC_redirect_t, dmem_req_t, mem_err_t;
  logic [15:0] stall_count_t;

  int n_assert = 0;
  int n_fail   = 0;

  // Output bundle order: PCw IFIDw IDEXw EXMEMw | IFIDf IDEXf EXMEMf | redir | req | err
  localparam logic [9:0] O_NORM  = 10'b1111_000_0_0_0;
  localparam logic [9:0] O_ZW    = 10'b1111_000_0_1_0;
  localparam logic [9:0] O_FRZ   = 10'b0000_000_0_1_0;
  localparam logic [9:0] O_ERR   = 10'b0000_000_0_0_1;
  localparam logic [9:0] O_TAKEN = 10'b1111_111_1_0_0;
  localparam logic [9:0] O_TKREQ = 10'b1111_111_1_1_0;
  localparam logic [9:0] O_HAZ   = 10'b0011_010_0_0_0;

  logic [9:0] outs, outs_t;
  assign outs   = {PC_write, IFID_write, IDEX_write, EXMEM_write,
                   IFID_flush, IDEX_flush, EXMEM_flush, PC_redirect, dmem_req, mem_err};
  assign outs_t = {PC_write_t, IFID_write_t, IDEX_write_t, EXMEM_write_t,
                   IFID_flush_t, IDEX_flush_t, EXMEM_flush_t, PC_redirect_t,
                   dmem_req_t, mem_err_t};

  pipeline_ctrl dut (
    .clk(clk), .reset(reset),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RD(IDEX_RD),
    .IFID_RS1(IFID_RS1), .IFID_RS2(IFID_RS2),
    .EXMEM_Branch(EXMEM_Branch), .EXMEM_Zero(EXMEM_Zero), .EXMEM_Jal(EXMEM_Jal),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
    .dmem_ready(dmem_ready),
    .PC_write(PC_write), .IFID_write(IFID_write), .IDEX_write(IDEX_write),
    .EXMEM_write(EXMEM_write), .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .EXMEM_flush(EXMEM_flush), .PC_redirect(PC_redirect), .dmem_req(dmem_req),
    .mem_err(mem_err), .stall_count(stall_count)
  );

  pipeline_ctrl #(.MEM_TIMEOUT(4)) dut_t (
    .clk(clk), .reset(reset),
    .IDEX_MemRead(IDEX_MemRead), .IDEX_RD(IDEX_RD),
    .IFID_RS1(IFID_RS1), .IFID_RS2(IFID_RS2),
    .EXMEM_Branch(EXMEM_Branch), .EXMEM_Zero(EXMEM_Zero), .EXMEM_Jal(EXMEM_Jal),
    .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_MemWrite(EXMEM_MemWrite),
    .dmem_ready(dmem_ready),
    .PC_write(PC_write_t), .IFID_write(IFID_write_t), .IDEX_write(IDEX_write_t),
    .EXMEM_write(EXMEM_write_t), .IFID_flush(IFID_flush_t), .IDEX_flush(IDEX_flush_t),
    .EXMEM_flush(EXMEM_flush_t), .PC_redirect(PC_redirect_t), .dmem_req(dmem_req_t),
    .mem_err(mem_err_t), .stall_count(stall_count_t)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    IDEX_MemRead = 0; IDEX_RD = 0; IFID_RS1 = 0; IFID_RS2 = 0;
    EXMEM_Branch = 0; EXMEM_Zero = 0; EXMEM_Jal = 0;
    EXMEM_MemRead = 0; EXMEM_MemWrite = 0; dmem_ready = 0;
  endtask

  task automatic pulse_reset();
    idle_inputs();
    #2 reset = 1'b1;
    #1;
    chk("rst_outs", {6'd0, outs}, {6'd0, O_NORM});
    chk("rst_stall", stall_count, 16'd0);
    chk("rst_outs_t", {6'd0, outs_t}, {6'd0, O_NORM});
    chk("rst_stall_t", stall_count_t, 16'd0);
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    #1;
    chk("reset_outs", {6'd0, outs}, {6'd0, O_NORM});
    chk("reset_stall", stall_count, 16'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle_outs", {6'd0, outs}, {6'd0, O_NORM});
    chk("idle_stall", stall_count, 16'd0);

    // Load-use hazard on RS2
    IDEX_MemRead = 1; IDEX_RD = 5'd5; IFID_RS1 = 5'd3; IFID_RS2 = 5'd5;
    #1 chk("hazard_outs", {6'd0, outs}, {6'd0, O_HAZ});
    tick();
    chk("hazard_stall", stall_count, 16'd1);
    idle_inputs();
    #1 chk("post_hazard_outs", {6'd0, outs}, {6'd0, O_NORM});
    tick();
    chk("post_hazard_stall", stall_count, 16'd1);

    // Load to x0 never stalls
    IDEX_MemRead = 1; IDEX_RD = 5'd0; IFID_RS1 = 5'd0;
    #1 chk("rd0_outs", {6'd0, outs}, {6'd0, O_NORM});
    tick();
    chk("rd0_stall", stall_count, 16'd1);

    // Taken branch beats a simultaneous hazard
    IDEX_MemRead = 1; IDEX_RD = 5'd7; IFID_RS1 = 5'd7;
    EXMEM_Branch = 1; EXMEM_Zero = 1;
    #1 chk("branch_haz_outs", {6'd0, outs}, {6'd0, O_TAKEN});
    tick();
    chk("branch_haz_stall", stall_count, 16'd1);
    idle_inputs();
    EXMEM_Branch = 1; EXMEM_Zero = 0;
    #1 chk("branch_nt_outs", {6'd0, outs}, {6'd0, O_NORM});
    EXMEM_Branch = 0; EXMEM_Jal = 1;
    #1 chk("jal_outs", {6'd0, outs}, {6'd0, O_TAKEN});
    tick();

    // Zero-wait store
    idle_inputs();
    EXMEM_MemWrite = 1; dmem_ready = 1;
    #1 chk("zero_wait_outs", {6'd0, outs}, {6'd0, O_ZW});
    tick();
    chk("zero_wait_stall", stall_count, 16'd1);

    // Three wait cycles then ready, with a jal held behind the freeze
    pulse_reset();
    EXMEM_MemRead = 1; EXMEM_Jal = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("wait_frz_outs", {6'd0, outs}, {6'd0, O_FRZ});
      tick();
    end
    dmem_ready = 1;
    #1 chk("wait_last_outs", {6'd0, outs}, {6'd0, O_FRZ});
    tick();
    chk("wait_stall", stall_count, 16'd4);
    chk("wait_stall_t", stall_count_t, 16'd4);
    chk("wait_redirect_outs", {6'd0, outs}, {6'd0, O_TKREQ});
    tick();
    chk("wait_no_more_stall", stall_count, 16'd4);

    // Timeout on the MEM_TIMEOUT=4 instance
    pulse_reset();
    EXMEM_MemRead = 1; dmem_ready = 0;
    repeat (4) tick();
    chk("pre_timeout_outs_t", {6'd0, outs_t}, {6'd0, O_FRZ});
    tick();
    chk("timeout_outs_t", {6'd0, outs_t}, {6'd0, O_ERR});
    chk("timeout_err_t", {15'd0, mem_err_t}, 16'd1);
    chk("timeout_dflt_outs", {6'd0, outs}, {6'd0, O_FRZ});
    dmem_ready = 1;
    #1 chk("err_ignore_ready_t", {6'd0, outs_t}, {6'd0, O_ERR});
    tick();
    chk("err_sticky_t", {6'd0, outs_t}, {6'd0, O_ERR});
    chk("err_stall_t", stall_count_t, 16'd6);
    pulse_reset();
    chk("after_reset_outs_t", {6'd0, outs_t}, {6'd0, O_NORM});
    chk("after_reset_stall_t", stall_count_t, 16'd0);

    // Long freeze drives stall_count into saturation
    EXMEM_MemRead = 1; dmem_ready = 0;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", stall_count, 16'hFFFE);
    chk("sat_err", {15'd0, mem_err}, 16'd1);
    tick();
    chk("sat_ffff", stall_count, 16'hFFFF);
    repeat (3) tick();
    chk("sat_hold", stall_count, 16'hFFFF);
    chk("sat_hold_t", stall_count_t, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 64, meaning the maximum MEM_WAIT cycles before the error state (legal range 1..255).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: IDEX_MemRead  in  1  the ID/EX instruction is a load.
REQ-005 SHALL have ports: IDEX_RD  in  5  ID/EX destination register.
REQ-006 SHALL have ports: IFID_RS1, IFID_RS2  in  5 each  IF/ID source registers.
REQ-007 SHALL have ports: EXMEM_Branch, EXMEM_Zero, EXMEM_Jal  in  1 each  EX/MEM branch/jump qualifiers.
REQ-008 SHALL have ports: EXMEM_MemRead, EXMEM_MemWrite  in  1 each  EX/MEM memory access.
REQ-009 SHALL have ports: dmem_ready  in  1  data memory completes the access this cycle.
REQ-010 SHALL have ports: PC_write, IFID_write, IDEX_write, EXMEM_write  out  1 each  stage load enables (1 = advance).
REQ-011 SHALL have ports: IFID_flush, IDEX_flush, EXMEM_flush  out  1 each  insert a bubble into the stage on the next edge.
REQ-012 SHALL have ports: PC_redirect  out  1  PC takes the EX/MEM target (branch/jal).
REQ-013 SHALL have ports: dmem_req  out  1  data memory request.
REQ-014 SHALL have ports: mem_err  out  1  sticky memory timeout flag.
REQ-015 SHALL have ports: stall_count  out  16  saturating count of freeze cycles.

Function
REQ-016 SHALL hold a registered FSM with states IDLE, MEM_WAIT and ERROR; all control outputs SHALL be combinational decodes of the state and the inputs.
REQ-017 SHALL define mem_op = EXMEM_MemRead | EXMEM_MemWrite; dmem_req = mem_op in IDLE, 1 in MEM_WAIT, and 0 in ERROR.
REQ-018 SHALL define freeze = (IDLE & mem_op & !dmem_ready) | MEM_WAIT | ERROR.
REQ-019 SHALL, when freeze = 1, drive PC_write, IFID_write, IDEX_write and EXMEM_write to 0, and all flushes and PC_redirect to 0.
REQ-020 SHALL define taken = (EXMEM_Branch & EXMEM_Zero) | EXMEM_Jal.
REQ-021 SHALL, when taken = 1 and freeze = 0, assert PC_redirect, IFID_flush, IDEX_flush and EXMEM_flush for exactly that cycle, with all write enables = 1.
REQ-022 SHALL define hazard = IDEX_MemRead & (IDEX_RD != 0) & (IDEX_RD == IFID_RS1 | IDEX_RD == IFID_RS2).
REQ-023 SHALL, when hazard = 1 and taken = 0 and freeze = 0, drive PC_write = 0, IFID_write = 0 and IDEX_flush = 1, with IDEX_write = 1 and EXMEM_write = 1 (one bubble).
REQ-024 SHALL apply priority freeze > taken > hazard; a redirect arriving during freeze is acted on in the first non-freeze cycle, because the EX/MEM inputs are held.
REQ-025 SHALL, with no condition active, drive all write enables = 1 and all flushes and PC_redirect = 0.
REQ-026 SHALL transition IDLE -> MEM_WAIT on mem_op & !dmem_ready; IDLE stays IDLE when dmem_ready = 1 (zero-wait access, no freeze).
REQ-027 SHALL transition MEM_WAIT -> IDLE on dmem_ready = 1; freeze SHALL still be 1 in that cycle and the pipeline SHALL advance on the following edge.
REQ-028 SHALL keep an 8-bit wait counter that is cleared on entry to MEM_WAIT and increments each MEM_WAIT cycle without dmem_ready.
REQ-029 SHALL, when the wait counter reaches MEM_TIMEOUT, transition MEM_WAIT -> ERROR and set mem_err = 1.
REQ-030 SHALL keep ERROR and mem_err until reset, with dmem_ready ignored in ERROR.
REQ-031 SHALL increment stall_count on every clock edge with freeze = 1 or a hazard bubble, and saturate it at 16'hFFFF without wrapping.

Reset
REQ-032 SHALL, on reset = 1, force the state to IDLE and clear the wait counter, mem_err and stall_count to 0, asynchronously and including mid-MEM_WAIT.
REQ-033 SHALL, while in reset, have outputs follow the IDLE decode: with idle inputs this gives write enables = 1, flushes = 0, PC_redirect = 0, dmem_req = 0 and mem_err = 0.

Verification
REQ-034 SHALL cover: IDEX_MemRead=1, IDEX_RD=5, IFID_RS2=5 -> PC_write=0, IFID_write=0, IDEX_flush=1 for 1 cycle, stall_count=1.
REQ-035 SHALL cover: IDEX_RD=0 with a matching RS1 and a load -> no stall, all write enables = 1.
REQ-036 SHALL cover: EXMEM_Branch=1, EXMEM_Zero=1 with a simultaneous load-use hazard -> PC_redirect plus all three flushes, no PC_write=0.
REQ-037 SHALL cover: EXMEM_MemRead=1 with dmem_ready low for 3 cycles then high -> dmem_req high for 4 cycles, freeze for 4 cycles, stall_count=4, back to IDLE.
REQ-038 SHALL cover: MEM_TIMEOUT=4 with dmem_ready held low -> ERROR after 4 MEM_WAIT cycles, mem_err=1, pipeline frozen; a reset pulse then restores IDLE, mem_err=0 and stall_count=0.
REQ-039 SHALL cover: forcing stall_count near 16'hFFFF via a long freeze -> it holds at 16'hFFFF.
